// File: rtl/prog_loader.sv
// Boot-time program loader.
// Consumes a valid/ready byte stream: one count byte, then a HI/LO byte pair per
// instruction. Each pair becomes a 12-bit word {HI[3:0], LO}. Words are written to
// instruction memory from address 0 upward. The processor is held in reset until
// the last word has been written.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to add a trailing XOR checksum
// byte. A mismatch parks the loader in an error state.
module prog_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               reload,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_rst,
  output logic               done,
  output logic               error
);

  typedef enum logic [2:0] {
    S_COUNT,
    S_HI,
    S_LO,
    S_CHK,
    S_RUN,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [8:0]          remaining_q, remaining_d;  // 9 bits: count byte 0 encodes 256
  logic [3:0]          opcode_q, opcode_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INSTR_W-1:0]  wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                accept;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
  logic                error_q, error_d;
`endif

  // A reload pulse masks the handshake and any pending write in its own cycle,
  // so a byte or write coinciding with the abort never takes effect.
  assign in_ready = ready_q & ~reload;
  assign imem_we  = we_q & ~reload;
  assign accept   = in_valid & in_ready;

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign error      = error_q;
`else
  assign error      = 1'b0;
`endif

  // Next-state, datapath and registered-output logic.
  always_comb begin
    // NOTE: every _d variable gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    state_d     = state_q;
    wptr_d      = wptr_q;
    remaining_d = remaining_q;
    opcode_d    = opcode_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      S_COUNT: begin
        if (accept) begin
          remaining_d = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          wptr_d      = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d      = 8'd0;
`endif
          state_d     = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          opcode_d = in_data[3:0];
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d   = csum_q ^ in_data;
`endif
          state_d  = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          we_d        = 1'b1;
          addr_d      = wptr_q;
          wdata_d     = INSTR_W'({opcode_q, in_data});
          remaining_d = remaining_q - 9'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d      = csum_q ^ in_data;
`endif
          if (remaining_q == 9'd1) begin
            // Last word: wptr is left on the final address, never wrapped.
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_RUN;
`endif
          end else begin
            wptr_d  = wptr_q + ADDR_W'(1);
            state_d = S_HI;
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? S_RUN : S_ERR;
        end
      end
`endif
      default: ;
    endcase

    if (reload) begin
      state_d = S_COUNT;
      wptr_d  = '0;
      we_d    = 1'b0;
    end

    ready_d   = (state_d == S_COUNT) || (state_d == S_HI) ||
                (state_d == S_LO)    || (state_d == S_CHK);
    // Status follows the state by one cycle so the processor leaves reset only
    // after the final write strobe has completed.
    done_d    = (state_q == S_RUN) && !reload;
    cpu_rst_d = (state_q != S_RUN) || reload;
`ifdef PROG_LOADER_CHECKSUM_EN
    error_d   = (state_q == S_ERR) && !reload;
`endif
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_COUNT;
      wptr_q      <= '0;
      remaining_q <= '0;
      opcode_q    <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      remaining_q <= remaining_d;
      opcode_q    <= opcode_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
      error_q     <= error_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. A stream-level model derives the expected
// memory image, write timing and final status from the byte stream alone.
module tb_prog_loader;

  typedef logic [7:0] bytes_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        reload = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [11:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log and cpu_rst release time, observed on the falling edge.
  int log_addr[$];
  int log_data[$];
  int log_cyc[$];
  int fall_cyc = -1;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      log_addr.push_back(int'(imem_addr));
      log_data.push_back(int'(imem_wdata));
      log_cyc.push_back(cyc);
    end
    if (cpu_rst === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    fall_cyc = -1;
  endtask

  // Append the XOR of all instruction bytes when the checksum build is used.
  function automatic bytes_t seal(input bytes_t s);
    bytes_t r = s;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'd0;
    for (int k = 1; k < r.size(); k++) x = x ^ r[k];
    r.push_back(x);
`endif
    return r;
  endfunction

  // Offer one byte (after optional random idle gaps); acc returns the cycle of
  // the accepting edge, or -1 if the bound expired. Entered and left on negedge.
  task automatic send_byte(input logic [7:0] b, input int gap_pct, output int acc);
    acc = -1;
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 100 && acc < 0; t++) begin
      #1;
      if (in_ready === 1'b1) acc = cyc + 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    repeat (2) @(negedge clk);
    clear_log();
  endtask

  // Stream a full load and compare image, write timing and final status.
  task automatic load_and_check(input string name, input bytes_t s,
                                input int gap_pct, input bit good);
    int  n;
    int  acc;
    int  last_acc;
    bit  timed_out;
    int  exp_cyc[$];
    logic [3:0] exp_st;
    logic [3:0] got_st;
    n = (s[0] == 8'd0) ? 256 : int'(s[0]);
    clear_log();
    timed_out = 1'b0;
    last_acc  = -1;
    foreach (s[k]) begin
      if (!timed_out) begin
        send_byte(s[k], gap_pct, acc);
        if (acc < 0) timed_out = 1'b1;
        last_acc = acc;
        if (k >= 2 && k % 2 == 0 && k <= 2 * n) exp_cyc.push_back(acc);
      end
    end
    n_cmp++;
    if (timed_out) begin
      n_err++;
      $display("FAIL %s handshake: byte not accepted within 100 cycles", name);
      return;
    end
    repeat (3) @(negedge clk);

    n_cmp++;
    if (log_addr.size() != n) begin
      n_err++;
      $display("FAIL %s write_count: got %0d expected %0d", name, log_addr.size(), n);
    end
    for (int i = 0; i < n && i < log_addr.size(); i++) begin
      logic [7:0]  hi;
      logic [11:0] w;
      hi = s[1 + 2 * i];
      w  = {hi[3:0], s[2 + 2 * i]};
      n_cmp++;
      if (log_addr[i] != i || log_data[i] != int'(w) || log_cyc[i] != exp_cyc[i]) begin
        n_err++;
        $display("FAIL %s write[%0d]: got addr=%0h data=%0h cyc=%0d expected addr=%0h data=%0h cyc=%0d",
                 name, i, log_addr[i], log_data[i], log_cyc[i], i, w, exp_cyc[i]);
      end
    end

    // Status bits {done, cpu_rst, error, in_ready}.
    exp_st = good ? 4'b1000 : 4'b0110;
    got_st = {done, cpu_rst, error, in_ready};
    n_cmp++;
    if (got_st !== exp_st) begin
      n_err++;
      $display("FAIL %s status{done,cpu_rst,error,in_ready}: got %b expected %b", name, got_st, exp_st);
    end
    n_cmp++;
    if (fall_cyc != (good ? last_acc + 1 : -1)) begin
      n_err++;
      $display("FAIL %s cpu_rst_release_cycle: got %0d expected %0d",
               name, fall_cyc, good ? last_acc + 1 : -1);
    end
  endtask

  task automatic test_reset();
    logic [24:0] got;
    #12;
    got = {in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error};
    n_cmp++;
    if (got !== {1'b0, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: got %h expected %h", got, {1'b0, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_cycle_ready: got %b expected 0", in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_second_cycle_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    load_and_check("basic", seal('{8'h02, 8'h01, 8'h05, 8'h0A, 8'hFF}), 0, 1'b1);
  endtask

  task automatic test_full256();
    bytes_t s;
    do_reload();
    s.push_back(8'h00);
    for (int k = 0; k < 512; k++) s.push_back(8'($urandom));
    load_and_check("full256", seal(s), 0, 1'b1);
  endtask

  task automatic test_gaps();
    do_reload();
    load_and_check("basic_gaps", seal('{8'h02, 8'h01, 8'h05, 8'h0A, 8'hFF}), 50, 1'b1);
    for (int r = 0; r < 4; r++) begin
      bytes_t s;
      int n;
      do_reload();
      n = int'($urandom_range(12, 1));
      s.push_back(8'(n));
      for (int k = 0; k < 2 * n; k++) s.push_back(8'($urandom));
      load_and_check("random_gaps", seal(s), 40, 1'b1);
    end
  endtask

  task automatic test_reload();
    int acc;
    do_reload();
    send_byte(8'h02, 0, acc);
    send_byte(8'h01, 0, acc);
    send_byte(8'h05, 0, acc);
    send_byte(8'h07, 0, acc);
    // Abort after the HI byte of word 1, offering a byte in the reload cycle.
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reload_ready: got %b expected 0", in_ready);
    end
    @(negedge clk);
    reload   = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (log_addr.size() != 1 || log_data[0] != 'h105 || log_addr[0] != 0 ||
        cpu_rst !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reload_abort: got writes=%0d cpu_rst=%b done=%b expected writes=1 cpu_rst=1 done=0",
               log_addr.size(), cpu_rst, done);
    end
    load_and_check("after_reload", seal('{8'h01, 8'h03, 8'h04}), 0, 1'b1);
  endtask

  task automatic test_checksum();
`ifdef PROG_LOADER_CHECKSUM_EN
    do_reload();
    load_and_check("checksum_good", '{8'h01, 8'h02, 8'h30, 8'h32}, 0, 1'b1);
    do_reload();
    load_and_check("checksum_bad", '{8'h01, 8'h02, 8'h30, 8'h33}, 0, 1'b0);
`endif
  endtask

  task automatic test_async_reset();
    int acc;
    logic [24:0] got;
    do_reload();
    send_byte(8'h02, 0, acc);
    send_byte(8'h01, 0, acc);
    send_byte(8'h05, 0, acc);
    send_byte(8'h0A, 0, acc);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    got = {in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error};
    n_cmp++;
    if (got !== {1'b0, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset_values: got %h expected %h", got, {1'b0, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    load_and_check("after_async_reset", seal('{8'h02, 8'h01, 8'h05, 8'h0A, 8'hFF}), 20, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full256();
    test_gaps();
    test_reload();
    test_checksum();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
